// File: rtl/nn_axil_sequencer.sv
// rtl/nn_axil_sequencer.sv - AXI4-Lite master that runs one inference on the neural_net slave
// Writes inputs, starts the core, polls status, then reads the result.
module nn_axil_sequencer #(
  parameter int unsigned NUM_IN     = 4,
  parameter logic [31:0] IN_BASE    = 32'h0000_0000,
  parameter logic [31:0] CTRL_ADDR  = 32'h0000_0010,
  parameter logic [31:0] STAT_ADDR  = 32'h0000_0014,
  parameter logic [31:0] OUT_ADDR   = 32'h0000_0018,
  parameter int unsigned POLL_LIMIT = 1024
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                start,
  input  logic [32*NUM_IN-1:0] in_data,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [1:0]          err_code,
  output logic [31:0]         result,
  output logic [31:0]         M_AXI_AWADDR,
  output logic [2:0]          M_AXI_AWPROT,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,
  output logic [31:0]         M_AXI_WDATA,
  output logic [3:0]          M_AXI_WSTRB,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,
  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY,
  output logic [31:0]         M_AXI_ARADDR,
  output logic [2:0]          M_AXI_ARPROT,
  output logic                M_AXI_ARVALID,
  input  logic                M_AXI_ARREADY,
  input  logic [31:0]         M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP,
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY
);
  localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WR_IN, S_WR_CTRL, S_POLL, S_RD_OUT} state_t;
  typedef enum logic [1:0] {P_ISSUE, P_REQ, P_RESP} phase_t;

  state_t        state;
  phase_t        phase;
  logic [31:0]   in_words [NUM_IN];
  logic [IW-1:0] idx;
  logic [31:0]   poll_cnt;
  logic          aw_done, w_done;
  logic          is_wr, aw_hs, w_hs, ar_hs;

  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB  = 4'hF;
  assign is_wr = (state == S_WR_IN) || (state == S_WR_CTRL);
  assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;
  assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= S_IDLE; phase <= P_ISSUE;
      for (int k = 0; k < NUM_IN; k++) in_words[k] <= '0;
      idx <= '0; poll_cnt <= '0; aw_done <= 1'b0; w_done <= 1'b0;
      busy <= 1'b0; done <= 1'b0; error <= 1'b0; err_code <= 2'd0; result <= '0;
      M_AXI_AWADDR <= '0; M_AXI_AWVALID <= 1'b0; M_AXI_WDATA <= '0; M_AXI_WVALID <= 1'b0;
      M_AXI_BREADY <= 1'b0; M_AXI_ARADDR <= '0; M_AXI_ARVALID <= 1'b0; M_AXI_RREADY <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        S_IDLE: begin
          // done/error still high means this is the pulse cycle: a start here is dropped
          if (start && !done && !error) begin
            for (int k = 0; k < NUM_IN; k++) in_words[k] <= in_data[32*k +: 32];
            busy <= 1'b1; err_code <= 2'd0; poll_cnt <= '0; idx <= '0;
            phase <= P_ISSUE; state <= S_WR_IN;
          end
        end
        default: begin
          case (phase)
            P_ISSUE: begin
              aw_done <= 1'b0; w_done <= 1'b0;
              if (is_wr) begin
                M_AXI_AWVALID <= 1'b1; M_AXI_WVALID <= 1'b1;
                if (state == S_WR_IN) begin
                  M_AXI_AWADDR <= IN_BASE + {{(30-IW){1'b0}}, idx, 2'b00};
                  M_AXI_WDATA  <= in_words[idx];
                end else begin
                  M_AXI_AWADDR <= CTRL_ADDR;
                  M_AXI_WDATA  <= 32'h1;
                end
              end else begin
                M_AXI_ARVALID <= 1'b1;
                M_AXI_ARADDR  <= (state == S_POLL) ? STAT_ADDR : OUT_ADDR;
              end
              phase <= P_REQ;
            end
            P_REQ: begin
              if (is_wr) begin
                if (aw_hs) begin M_AXI_AWVALID <= 1'b0; aw_done <= 1'b1; end
                if (w_hs)  begin M_AXI_WVALID  <= 1'b0; w_done  <= 1'b1; end
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                  M_AXI_BREADY <= 1'b1; phase <= P_RESP;
                end
              end else if (ar_hs) begin
                M_AXI_ARVALID <= 1'b0; M_AXI_RREADY <= 1'b1; phase <= P_RESP;
              end
            end
            default: begin
              if (is_wr) begin
                if (M_AXI_BVALID) begin
                  M_AXI_BREADY <= 1'b0;
                  phase <= P_ISSUE;
                  if (M_AXI_BRESP != 2'b00) begin
                    error <= 1'b1; err_code <= 2'd1; busy <= 1'b0; state <= S_IDLE;
                  end else if (state == S_WR_IN && idx != IW'(NUM_IN - 1)) begin
                    idx <= idx + 1'b1;
                  end else if (state == S_WR_IN) begin
                    state <= S_WR_CTRL;
                  end else begin
                    state <= S_POLL;
                  end
                end
              end else if (M_AXI_RVALID) begin
                M_AXI_RREADY <= 1'b0;
                phase <= P_ISSUE;
                if (M_AXI_RRESP != 2'b00) begin
                  error <= 1'b1; err_code <= 2'd2; busy <= 1'b0; state <= S_IDLE;
                end else if (state == S_RD_OUT) begin
                  result <= M_AXI_RDATA; done <= 1'b1; busy <= 1'b0; state <= S_IDLE;
                end else if (M_AXI_RDATA[0]) begin
                  state <= S_RD_OUT;
                end else if (poll_cnt + 32'd1 >= POLL_LIMIT) begin
                  error <= 1'b1; err_code <= 2'd3; busy <= 1'b0; state <= S_IDLE;
                end else begin
                  poll_cnt <= poll_cnt + 32'd1;
                end
              end
            end
          endcase
        end
      endcase
    end
  end
endmodule
